bsg_async_credit_counter_spend: RTL and testbench

// - Read-domain consumer of a synchronized gray-coded "credits returned" pointer.
// - Each cycle it converts the pointer to binary and tracks a local "credits spent" pointer.
// - It keeps a registered count of available credits and grants spend requests through a

---
 rtl/bsg_async_credit_counter_spend_pkg.sv | 9 +
 rtl/bsg_gray_to_binary.sv | 13 +
 rtl/bsg_async_credit_counter_spend.sv | 72 +++++++
 tb/tb_bsg_async_credit_counter_spend.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bsg_async_credit_counter_spend_pkg.sv
// Shared helpers for the read-domain credit spend counter.
package bsg_async_credit_counter_spend_pkg;

  // Width of a counter holding 0..n-1, never less than one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module bsg_gray_to_binary #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  for (genvar i = 0; i < width_p; i++) begin : g_bit
    assign binary_o[i] = ^gray_i[width_p-1:i];
  end

endmodule

// File: rtl/bsg_async_credit_counter_spend.sv
// Read-domain credit counter: converts the synchronized gray return pointer, tracks spends,
// and keeps a registered available-credit count plus a sticky protocol error flag.
module bsg_async_credit_counter_spend
  import bsg_async_credit_counter_spend_pkg::*;
#(
  parameter  int lg_size_p       = 4,
  parameter  int start_credits_p = 8,
  localparam int credit_width_lp = safe_clog2(start_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [lg_size_p-1:0]       w_ptr_gray_rsync_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [credit_width_lp-1:0] credits_o,
  output logic [lg_size_p-1:0]       spent_ptr_o,
  output logic                       error_o
);

  localparam logic [lg_size_p-1:0] start_lp = lg_size_p'(start_credits_p);

  logic [lg_size_p-1:0] gray_r, ret_bin_r, ret_bin_n, spent_r, spent_n;
  logic [lg_size_p-1:0] avail_r, avail_n, ret_delta, out_n, gray_diff;
  logic [lg_size_p-1:0] spend_inc;
  logic                 ready_r, error_r, spend, gray_skip, overflow;

  // Kept apart from the synchronizer flops so the conversion path starts at a clean register.
  bsg_gray_to_binary #(.width_p(lg_size_p)) gray_to_bin (
    .gray_i   (gray_r),
    .binary_o (ret_bin_n)
  );

  assign spend     = v_i & ready_r;
  assign spend_inc = lg_size_p'(spend);
  assign spent_n   = spent_r + spend_inc;

  // avail tracks start - (spent - returned) incrementally, so every step stays mod 2**lg_size_p.
  assign ret_delta = ret_bin_n - ret_bin_r;
  assign avail_n   = avail_r + ret_delta - spend_inc;
  assign out_n     = start_lp - avail_n;

  // More than one bit set in the sample-to-sample XOR means the gray pointer skipped.
  assign gray_diff = w_ptr_gray_rsync_i ^ gray_r;
  assign gray_skip = (gray_diff & (gray_diff - 1'b1)) != '0;
  assign overflow  = out_n > start_lp;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gray_r    <= '0;
      ret_bin_r <= '0;
      spent_r   <= '0;
      avail_r   <= start_lp;
      ready_r   <= 1'b1;
      error_r   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
      // gray_r -> ret_bin_r pipeline really is two stages regardless of statement order.
      gray_r    <= w_ptr_gray_rsync_i;
      ret_bin_r <= ret_bin_n;
      spent_r   <= spent_n;
      avail_r   <= avail_n;
      ready_r   <= avail_n != '0;
      error_r   <= error_r | gray_skip | overflow;
    end
  end

  assign ready_o     = ready_r;
  assign credits_o   = avail_r[credit_width_lp-1:0];
  assign spent_ptr_o = spent_r;
  assign error_o     = error_r;

endmodule

// File: tb/tb_bsg_async_credit_counter_spend.sv
// Directed bench for the credit spend counter; inputs change and outputs are sampled on negedge.
module tb_bsg_async_credit_counter_spend;

  localparam int lg_size_p       = 4;
  localparam int start_credits_p = 8;
  localparam int credit_width_lp = 4;

  logic                       clk_i = 1'b0;
  logic                       reset_i;
  logic [lg_size_p-1:0]       w_ptr_gray_rsync_i;
  logic                       v_i;
  logic                       ready_o;
  logic [credit_width_lp-1:0] credits_o;
  logic [lg_size_p-1:0]       spent_ptr_o;
  logic                       error_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  bsg_async_credit_counter_spend #(
    .lg_size_p       (lg_size_p),
    .start_credits_p (start_credits_p)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .w_ptr_gray_rsync_i (w_ptr_gray_rsync_i),
    .v_i                (v_i),
    .ready_o            (ready_o),
    .credits_o          (credits_o),
    .spent_ptr_o        (spent_ptr_o),
    .error_o            (error_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [lg_size_p-1:0] bin2gray(input int b);
    logic [lg_size_p-1:0] t;
    t = lg_size_p'(b);
    return t ^ (t >> 1);
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    v_i = 1'b0;
    w_ptr_gray_rsync_i = '0;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = 1'b0;
    w_ptr_gray_rsync_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_credits", credits_o, 8);
    check("rst_ready", ready_o, 1);
    check("rst_spent", spent_ptr_o, 0);
    check("rst_error", error_o, 0);
    reset_i = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      check("idle_credits", credits_o, 8);
      check("idle_ready", ready_o, 1);
      check("idle_error", error_o, 0);
    end

    // 2: spend until exhausted; requests without ready are ignored
    v_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      check("spend_credits", credits_o, (k <= 8) ? 8 - k : 0);
      check("spend_ready", ready_o, (k < 8) ? 1 : 0);
    end
    v_i = 1'b0;
    check("spend_ptr", spent_ptr_o, 8);
    check("spend_error", error_o, 0);

    // 3: returns arrive two cycles after the pointer moves
    w_ptr_gray_rsync_i = bin2gray(1);
    @(negedge clk_i); check("ret1_lat1", credits_o, 0);
    @(negedge clk_i); check("ret1_lat2", credits_o, 1);
    check("ret1_ready", ready_o, 1);
    w_ptr_gray_rsync_i = bin2gray(2);
    @(negedge clk_i); check("ret2_lat1", credits_o, 1);
    @(negedge clk_i); check("ret2_lat2", credits_o, 2);
    check("ret_error", error_o, 0);

    // 4: one spend and one return per cycle, both pointers wrapping
    v_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w_ptr_gray_rsync_i = bin2gray(3 + i);
      @(negedge clk_i);
      check("steady_credits", credits_o, 1);
      check("steady_error", error_o, 0);
    end
    v_i = 1'b0;
    check("wrap_spent_ptr", spent_ptr_o, 0);
    repeat (2) @(negedge clk_i);
    check("wrap_drain_credits", credits_o, 2);
    check("wrap_drain_error", error_o, 0);

    // 5a: gray pointer skips two codes in one sample
    do_reset();
    check("gj_rst_credits", credits_o, 8);
    v_i = 1'b1;
    repeat (4) @(negedge clk_i);
    v_i = 1'b0;
    check("gj_pre_credits", credits_o, 4);
    check("gj_pre_error", error_o, 0);
    w_ptr_gray_rsync_i = bin2gray(2);
    @(negedge clk_i);
    check("gj_error", error_o, 1);
    check("gj_credits_hold", credits_o, 4);
    @(negedge clk_i);
    check("gj_credits_cont", credits_o, 6);
    repeat (3) @(negedge clk_i);
    check("gj_sticky", error_o, 1);

    // 5b: more credits returned than spent
    do_reset();
    check("ov_rst_error", error_o, 0);
    w_ptr_gray_rsync_i = bin2gray(1);
    @(negedge clk_i);
    check("ov_pre_error", error_o, 0);
    @(negedge clk_i);
    check("ov_error", error_o, 1);
    check("ov_credits", credits_o, 9);
    repeat (3) @(negedge clk_i);
    check("ov_sticky", error_o, 1);

    // 6: asynchronous reset between edges during a burst
    do_reset();
    check("ar_pre_error", error_o, 0);
    v_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("ar_burst_credits", credits_o, 5);
    check("ar_burst_spent", spent_ptr_o, 3);
    @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("ar_credits", credits_o, 8);
    check("ar_ready", ready_o, 1);
    check("ar_spent", spent_ptr_o, 0);
    check("ar_error", error_o, 0);
    @(negedge clk_i);
    check("ar_hold_credits", credits_o, 8);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("ar_resume_credits", credits_o, 7);
    check("ar_resume_spent", spent_ptr_o, 1);
    @(negedge clk_i);
    check("ar_resume_credits2", credits_o, 6);
    v_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
